// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB4 register bank: FSM state encoding,
// privilege bit position, and byte-strobe merge.
package apb_pkg;

    typedef enum logic {IDLE, ACCESS} apb_state_e;

    localparam int unsigned APB_PROT_PRIV_BIT = 0;
    localparam int unsigned WAIT_CNT_W        = 4;

    // Operates on the widest legal bus (32 bits); narrower buses zero-extend and truncate.
    function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/apb4_slv_fsm.sv
// APB4 setup/access sequencer: latches the transfer fields at setup, counts wait
// states, detects aborts and flags the completion cycle.
module apb4_slv_fsm
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                pclk_i,
    input  logic                rst_ni,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic                pwrite_i,
    input  logic [DATA_W-1:0]   pwdata_i,
    input  logic [DATA_W/8-1:0] pstrb_i,
    input  logic [2:0]          pprot_i,
    output logic                ready_o,
    output logic                complete_o,
    output logic [ADDR_W-1:0]   addr_o,
    output logic                write_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] strb_o,
    output logic                priv_o
);

    localparam logic [WAIT_CNT_W-1:0] WaitInit = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e              state_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    write_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W/8-1:0]     strb_q;
    logic                    priv_q;
    logic [1:0]              unused_prot;

    assign unused_prot = pprot_i[2:1];

    always_ff @(posedge pclk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            priv_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        addr_q  <= paddr_i;
                        write_q <= pwrite_i;
                        wdata_q <= pwdata_i;
                        strb_q  <= pstrb_i;
                        priv_q  <= pprot_i[APB_PROT_PRIV_BIT];
                        cnt_q   <= WaitInit;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    // A dropped psel abandons the transfer regardless of the counter.
                    if (!psel_i) begin
                        state_q <= IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (penable_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o    = (state_q == ACCESS) && (cnt_q == '0);
    assign complete_o = ready_o && psel_i && penable_i;
    assign addr_o     = addr_q;
    assign write_o    = write_q;
    assign wdata_o    = wdata_q;
    assign strb_o     = strb_q;
    assign priv_o     = priv_q;

endmodule

// File: rtl/apb4_slave_regbank.sv
// APB4 completer owning NUM_REGS registers with byte-strobe writes, read-only
// hardware-sourced registers, privilege checking and per-register write pulses.
module apb4_slave_regbank
    import apb_pkg::*;
#(
    parameter int unsigned          ADDR_W      = 12,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          NUM_REGS    = 16,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0,
    parameter logic [NUM_REGS-1:0]  PRIV_MASK   = '0,
    parameter logic [DATA_W-1:0]    RST_VAL     = '0
) (
    input  logic                         pclk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            paddr,
    input  logic                         psel,
    input  logic                         penable,
    input  logic                         pwrite,
    input  logic [DATA_W-1:0]            pwdata,
    input  logic [DATA_W/8-1:0]          pstrb,
    input  logic [2:0]                   pprot,
    output logic [DATA_W-1:0]            prdata,
    output logic                         pready,
    output logic                         pslverr,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_rdata_i,
    output logic [NUM_REGS-1:0]          wr_pulse_o
);

    localparam int unsigned       Lsb     = $clog2(DATA_W / 8);
    localparam logic [ADDR_W-1:0] LowMask = ADDR_W'((1 << Lsb) - 1);

    logic                  ready;
    logic                  complete;
    logic [ADDR_W-1:0]     lat_addr;
    logic                  lat_write;
    logic [DATA_W-1:0]     lat_wdata;
    logic [DATA_W/8-1:0]   lat_strb;
    logic                  lat_priv;

    apb4_slv_fsm #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .pclk_i     (pclk),
        .rst_ni     (rst_n),
        .psel_i     (psel),
        .penable_i  (penable),
        .paddr_i    (paddr),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pstrb_i    (pstrb),
        .pprot_i    (pprot),
        .ready_o    (ready),
        .complete_o (complete),
        .addr_o     (lat_addr),
        .write_o    (lat_write),
        .wdata_o    (lat_wdata),
        .strb_o     (lat_strb),
        .priv_o     (lat_priv)
    );

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [31:0]         idx;
    logic                in_range, unaligned, sel_ro, sel_priv, err, wr_en;
    logic [DATA_W-1:0]   rd_val;
    logic [31:0]         merged;

    assign idx       = 32'(lat_addr >> Lsb);
    assign in_range  = idx < 32'(NUM_REGS);
    assign unaligned = |(lat_addr & LowMask);

    always_comb begin
        sel_ro   = 1'b0;
        sel_priv = 1'b0;
        rd_val   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 32'(i)) begin
                sel_ro   = RO_MASK[i];
                sel_priv = PRIV_MASK[i];
                rd_val   = RO_MASK[i] ? hw_rdata_i[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    assign err   = !in_range || unaligned || (lat_write && sel_ro) || (sel_priv && !lat_priv);
    assign wr_en = complete && lat_write && !err;

    // Outputs depend only on FSM state and latched fields, never on live paddr/pwdata.
    assign pready  = ready;
    assign pslverr = ready && err;
    assign prdata  = (ready && !lat_write && !err) ? rd_val : '0;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        merged     = '0;
        if (wr_en) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (idx == 32'(i) && !RO_MASK[i]) begin
                    merged        = strb_merge(32'(regs_q[i]), 32'(lat_wdata), 4'(lat_strb));
                    regs_d[i]     = merged[DATA_W-1:0];
                    wr_pulse_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RST_VAL;
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Self-checking bench for apb4_slave_regbank: three instances with 0, 3 and 2
// wait states share one APB bus, each selected by its own psel bit.
module tb_apb4_slave_regbank;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [11:0]   paddr;
    logic [2:0]    psel;
    logic          penable, pwrite;
    logic [31:0]   pwdata;
    logic [3:0]    pstrb;
    logic [2:0]    pprot;
    logic [511:0]  hw_rdata;

    logic [2:0][31:0]  prdata_a;
    logic [2:0]        pready_a, pslverr_a;
    logic [2:0][511:0] regs_a;
    logic [2:0][15:0]  pulse_a;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [15:0] pulse;
        int          waits;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    apb4_slave_regbank #(.WAIT_STATES(0), .RO_MASK(16'h0002), .PRIV_MASK(16'h0010)) u_dut0 (
        .pclk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[0]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_a[0]), .pready(pready_a[0]), .pslverr(pslverr_a[0]),
        .regs_o(regs_a[0]), .hw_rdata_i(hw_rdata), .wr_pulse_o(pulse_a[0])
    );

    apb4_slave_regbank #(.WAIT_STATES(3), .RO_MASK(16'h0002), .PRIV_MASK(16'h0010)) u_dut3 (
        .pclk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[1]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_a[1]), .pready(pready_a[1]), .pslverr(pslverr_a[1]),
        .regs_o(regs_a[1]), .hw_rdata_i(hw_rdata), .wr_pulse_o(pulse_a[1])
    );

    apb4_slave_regbank #(.WAIT_STATES(2), .RO_MASK(16'h0002), .PRIV_MASK(16'h0010)) u_dut2 (
        .pclk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[2]), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata_a[2]), .pready(pready_a[2]), .pslverr(pslverr_a[2]),
        .regs_o(regs_a[2]), .hw_rdata_i(hw_rdata), .wr_pulse_o(pulse_a[2])
    );

    // Starts just after a posedge (or at a negedge), drives setup then access, and
    // compares against the scoreboard entry when pready rises.
    task automatic apb_xfer(input string name, input int s, input logic wr,
                            input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [2:0] prot,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic [15:0] exp_pulse, input int exp_waits, input bit b2b);
        exp_t        e;
        int          waits;
        int          idx;
        bit          done;
        logic [31:0] pre;
        idx = int'(addr[11:2]);
        pre = (idx < 16) ? regs_a[s][idx*32 +: 32] : 32'h0;
        e   = '{exp_rdata, exp_err, exp_pulse, exp_waits};
        sb_q.push_back(e);
        psel = '0; psel[s] = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1 penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (wr && idx < 16) begin
                total++;
                if (regs_a[s][idx*32 +: 32] !== pre) begin
                    bad++;
                    $display("FAIL %s early_write: reg=%h want %h", name, regs_a[s][idx*32 +: 32], pre);
                end
            end
            if (pready_a[s]) done = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        e = sb_q.pop_front();
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: pready=%b want 1", name, pready_a[s]);
        end else begin
            if (waits !== e.waits) begin
                bad++;
                $display("FAIL %s waits: got %0d want %0d", name, waits, e.waits);
            end
            total++;
            if (prdata_a[s] !== e.rdata) begin
                bad++;
                $display("FAIL %s prdata: got %h want %h", name, prdata_a[s], e.rdata);
            end
            total++;
            if (pslverr_a[s] !== e.err) begin
                bad++;
                $display("FAIL %s pslverr: got %b want %b", name, pslverr_a[s], e.err);
            end
        end
        @(posedge clk); #1;
        psel = '0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
        if (!b2b) begin
            @(negedge clk);
            total++;
            if (pulse_a[s] !== e.pulse) begin
                bad++;
                $display("FAIL %s pulse: got %h want %h", name, pulse_a[s], e.pulse);
            end
            @(negedge clk);
            total++;
            if (pulse_a[s] !== 16'h0) begin
                bad++;
                $display("FAIL %s pulse_len: got %h want 0000", name, pulse_a[s]);
            end
        end
    endtask

    task automatic check_idle_outputs(input string name, input int s);
        total++;
        if (pready_a[s] !== 1'b0 || pslverr_a[s] !== 1'b0) begin
            bad++;
            $display("FAIL %s ready/err: got %b%b want 00", name, pready_a[s], pslverr_a[s]);
        end
        total++;
        if (prdata_a[s] !== 32'h0) begin
            bad++;
            $display("FAIL %s prdata: got %h want 0", name, prdata_a[s]);
        end
        total++;
        if (pulse_a[s] !== 16'h0) begin
            bad++;
            $display("FAIL %s pulse: got %h want 0", name, pulse_a[s]);
        end
        total++;
        if (regs_a[s] !== 512'h0) begin
            bad++;
            $display("FAIL %s regs: got %h want 0", name, regs_a[s]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0; hw_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) check_idle_outputs("reset", s);
        apb_xfer("rd_reg3", 0, 1'b0, 12'h00C, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_strobe_write();
        apb_xfer("wr_reg2", 0, 1'b1, 12'h008, 32'hDEADBEEF, 4'b0101, 3'b000,
                 32'h0, 1'b0, 16'h0004, 0, 1'b0);
        apb_xfer("rd_reg2", 0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b000,
                 32'h00AD00EF, 1'b0, 16'h0, 0, 1'b0);
        apb_xfer("rd_reg2_strb", 0, 1'b0, 12'h008, 32'h0, 4'hF, 3'b000,
                 32'h00AD00EF, 1'b0, 16'h0, 0, 1'b0);
        apb_xfer("wr_reg6_nostrb", 0, 1'b1, 12'h018, 32'hFFFFFFFF, 4'h0, 3'b000,
                 32'h0, 1'b0, 16'h0040, 0, 1'b0);
        apb_xfer("rd_reg6", 0, 1'b0, 12'h018, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_wait_states();
        apb_xfer("ws3_wr_reg0", 1, 1'b1, 12'h000, 32'hCAFEF00D, 4'hF, 3'b000,
                 32'h0, 1'b0, 16'h0001, 3, 1'b0);
        apb_xfer("ws3_rd_reg0", 1, 1'b0, 12'h000, 32'h0, 4'h0, 3'b000,
                 32'hCAFEF00D, 1'b0, 16'h0, 3, 1'b0);
    endtask

    task automatic test_errors();
        logic [11:0] addrs [7] = '{12'h040, 12'h040, 12'h006, 12'h006, 12'h004, 12'h010, 12'h010};
        logic        wrs   [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  prots [7] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000, 3'b000};
        for (int i = 0; i < 7; i++) begin
            apb_xfer($sformatf("err%0d", i), 0, wrs[i], addrs[i], 32'hFFFFFFFF, 4'hF, prots[i],
                     32'h0, 1'b1, 16'h0, 0, 1'b0);
        end
        apb_xfer("err_rd_reg2", 0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b000,
                 32'h00AD00EF, 1'b0, 16'h0, 0, 1'b0);
        apb_xfer("err_rd_reg4", 0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, 32'h0, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_ro_priv();
        hw_rdata[63:32] = 32'h12345678;
        apb_xfer("rd_ro_reg1", 0, 1'b0, 12'h004, 32'h0, 4'h0, 3'b000,
                 32'h12345678, 1'b0, 16'h0, 0, 1'b0);
        apb_xfer("wr_priv_reg4", 0, 1'b1, 12'h010, 32'h55AA55AA, 4'hF, 3'b001,
                 32'h0, 1'b0, 16'h0010, 0, 1'b0);
        apb_xfer("rd_priv_reg4", 0, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001,
                 32'h55AA55AA, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        apb_xfer("b2b_wr_reg7", 0, 1'b1, 12'h01C, 32'h11223344, 4'hF, 3'b000,
                 32'h0, 1'b0, 16'h0080, 0, 1'b1);
        apb_xfer("b2b_rd_reg7", 0, 1'b0, 12'h01C, 32'h0, 4'h0, 3'b000,
                 32'h11223344, 1'b0, 16'h0, 0, 1'b1);
        apb_xfer("b2b_rd_reg2", 0, 1'b0, 12'h008, 32'h0, 4'h0, 3'b000,
                 32'h00AD00EF, 1'b0, 16'h0, 0, 1'b0);
    endtask

    task automatic test_abort_and_reset();
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000;
        pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b000;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 psel = '0; penable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_idle_outputs("abort", 2);
        apb_xfer("abort_rd_reg0", 2, 1'b0, 12'h000, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 16'h0, 2, 1'b0);
        apb_xfer("ws2_wr_reg3", 2, 1'b1, 12'h00C, 32'h00000077, 4'hF, 3'b000,
                 32'h0, 1'b0, 16'h0008, 2, 1'b0);
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014;
        pwdata = 32'h99999999; pstrb = 4'hF;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1; psel = '0; penable = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset", 2);
        apb_xfer("post_rst_rd_reg5", 2, 1'b0, 12'h014, 32'h0, 4'h0, 3'b000,
                 32'h0, 1'b0, 16'h0, 2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_strobe_write();
        test_wait_states();
        test_errors();
        test_ro_priv();
        test_back_to_back();
        test_abort_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
